// File: rtl/dispatcher_host_pkg.sv
// Descriptor layout shared by the host workgroup queue and its loader.
// Fields are packed LSB-first in the order of the offset list below.
package dispatcher_host_pkg;

    localparam int unsigned WG_ID_W      = 6;
    localparam int unsigned WF_COUNT_W   = 4;
    localparam int unsigned WAVE_ITEM_W  = 6;
    localparam int unsigned VGPR_ID_W    = 8;
    localparam int unsigned SGPR_ID_W    = 4;
    localparam int unsigned LDS_ID_W     = 8;
    localparam int unsigned GDS_ID_W     = 14;
    localparam int unsigned MEM_ADDR_W   = 32;

    localparam int unsigned VGPR_SIZE_W  = VGPR_ID_W + 1;
    localparam int unsigned SGPR_SIZE_W  = SGPR_ID_W + 1;
    localparam int unsigned LDS_SIZE_W   = LDS_ID_W + 1;
    localparam int unsigned GDS_SIZE_W   = GDS_ID_W + 1;

    localparam int unsigned WG_ID_LSB       = 0;
    localparam int unsigned WG_ID_MSB       = WG_ID_LSB + WG_ID_W - 1;
    localparam int unsigned NUM_WF_LSB      = WG_ID_MSB + 1;
    localparam int unsigned NUM_WF_MSB      = NUM_WF_LSB + WF_COUNT_W - 1;
    localparam int unsigned WF_SIZE_LSB     = NUM_WF_MSB + 1;
    localparam int unsigned WF_SIZE_MSB     = WF_SIZE_LSB + WAVE_ITEM_W - 1;
    localparam int unsigned VGPR_TOT_LSB    = WF_SIZE_MSB + 1;
    localparam int unsigned VGPR_TOT_MSB    = VGPR_TOT_LSB + VGPR_SIZE_W - 1;
    localparam int unsigned SGPR_TOT_LSB    = VGPR_TOT_MSB + 1;
    localparam int unsigned SGPR_TOT_MSB    = SGPR_TOT_LSB + SGPR_SIZE_W - 1;
    localparam int unsigned LDS_TOT_LSB     = SGPR_TOT_MSB + 1;
    localparam int unsigned LDS_TOT_MSB     = LDS_TOT_LSB + LDS_SIZE_W - 1;
    localparam int unsigned GDS_TOT_LSB     = LDS_TOT_MSB + 1;
    localparam int unsigned GDS_TOT_MSB     = GDS_TOT_LSB + GDS_SIZE_W - 1;
    localparam int unsigned VGPR_WF_LSB     = GDS_TOT_MSB + 1;
    localparam int unsigned VGPR_WF_MSB     = VGPR_WF_LSB + VGPR_SIZE_W - 1;
    localparam int unsigned SGPR_WF_LSB     = VGPR_WF_MSB + 1;
    localparam int unsigned SGPR_WF_MSB     = SGPR_WF_LSB + SGPR_SIZE_W - 1;
    localparam int unsigned START_PC_LSB    = SGPR_WF_MSB + 1;
    localparam int unsigned START_PC_MSB    = START_PC_LSB + MEM_ADDR_W - 1;
    localparam int unsigned DESC_W          = START_PC_MSB + 1;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]  start_pc;
        logic [SGPR_SIZE_W-1:0] sgpr_per_wf;
        logic [VGPR_SIZE_W-1:0] vgpr_per_wf;
        logic [GDS_SIZE_W-1:0]  gds_total;
        logic [LDS_SIZE_W-1:0]  lds_total;
        logic [SGPR_SIZE_W-1:0] sgpr_total;
        logic [VGPR_SIZE_W-1:0] vgpr_total;
        logic [WAVE_ITEM_W-1:0] wf_size;
        logic [WF_COUNT_W-1:0]  num_wf;
        logic [WG_ID_W-1:0]     wg_id;
    } desc_t;

    function automatic logic [DESC_W-1:0] pack_desc(desc_t d);
        logic [DESC_W-1:0] raw;
        raw = '0;
        raw[WG_ID_MSB:WG_ID_LSB]       = d.wg_id;
        raw[NUM_WF_MSB:NUM_WF_LSB]     = d.num_wf;
        raw[WF_SIZE_MSB:WF_SIZE_LSB]   = d.wf_size;
        raw[VGPR_TOT_MSB:VGPR_TOT_LSB] = d.vgpr_total;
        raw[SGPR_TOT_MSB:SGPR_TOT_LSB] = d.sgpr_total;
        raw[LDS_TOT_MSB:LDS_TOT_LSB]   = d.lds_total;
        raw[GDS_TOT_MSB:GDS_TOT_LSB]   = d.gds_total;
        raw[VGPR_WF_MSB:VGPR_WF_LSB]   = d.vgpr_per_wf;
        raw[SGPR_WF_MSB:SGPR_WF_LSB]   = d.sgpr_per_wf;
        raw[START_PC_MSB:START_PC_LSB] = d.start_pc;
        return raw;
    endfunction

    function automatic desc_t unpack_desc(logic [DESC_W-1:0] raw);
        desc_t d;
        d.wg_id       = raw[WG_ID_MSB:WG_ID_LSB];
        d.num_wf      = raw[NUM_WF_MSB:NUM_WF_LSB];
        d.wf_size     = raw[WF_SIZE_MSB:WF_SIZE_LSB];
        d.vgpr_total  = raw[VGPR_TOT_MSB:VGPR_TOT_LSB];
        d.sgpr_total  = raw[SGPR_TOT_MSB:SGPR_TOT_LSB];
        d.lds_total   = raw[LDS_TOT_MSB:LDS_TOT_LSB];
        d.gds_total   = raw[GDS_TOT_MSB:GDS_TOT_LSB];
        d.vgpr_per_wf = raw[VGPR_WF_MSB:VGPR_WF_LSB];
        d.sgpr_per_wf = raw[SGPR_WF_MSB:SGPR_WF_LSB];
        d.start_pc    = raw[START_PC_MSB:START_PC_LSB];
        return d;
    endfunction

endpackage

// File: rtl/dispatcher_host_desc_fifo.sv
// Flop-based synchronous FIFO with flush; read data comes straight from the head storage flop.
module dispatcher_host_desc_fifo
    import dispatcher_host_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == (DEPTH_LOG2 + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Flush wins over both ends of the queue in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) begin
                    mem_q[wr_ptr_q] <= wdata_i;
                    wr_ptr_q        <= wr_ptr_q + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dispatcher_host_wg_queue.sv
// Host-side workgroup source: queues descriptors for the dispatcher and tracks per-WG
// wavefront completion, raising a registered done pulse when a WG's last WF retires.
module dispatcher_host_wg_queue
    import dispatcher_host_pkg::*;
#(
    parameter int unsigned WG_ID_WIDTH      = WG_ID_W,
    parameter int unsigned WF_COUNT_WIDTH   = WF_COUNT_W,
    parameter int unsigned WAVE_ITEM_WIDTH  = WAVE_ITEM_W,
    parameter int unsigned VGPR_ID_WIDTH    = VGPR_ID_W,
    parameter int unsigned SGPR_ID_WIDTH    = SGPR_ID_W,
    parameter int unsigned LDS_ID_WIDTH     = LDS_ID_W,
    parameter int unsigned GDS_ID_WIDTH     = GDS_ID_W,
    parameter int unsigned MEM_ADDR_WIDTH   = MEM_ADDR_W,
    parameter int unsigned QUEUE_DEPTH_LOG2 = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [DESC_W-1:0]           load_desc,
    input  logic                        host_flush,
    output logic                        host_wg_valid,
    output logic [WG_ID_WIDTH-1:0]      host_wg_id,
    output logic [WF_COUNT_WIDTH-1:0]   host_num_wf,
    output logic [WAVE_ITEM_WIDTH-1:0]  host_wf_size,
    output logic [VGPR_ID_WIDTH:0]      host_vgpr_size_total,
    output logic [SGPR_ID_WIDTH:0]      host_sgpr_size_total,
    output logic [LDS_ID_WIDTH:0]       host_lds_size_total,
    output logic [GDS_ID_WIDTH:0]       host_gds_size_total,
    output logic [VGPR_ID_WIDTH:0]      host_vgpr_size_per_wf,
    output logic [SGPR_ID_WIDTH:0]      host_sgpr_size_per_wf,
    output logic [MEM_ADDR_WIDTH-1:0]   host_start_pc,
    input  logic                        inflight_wg_buffer_host_rcvd_ack,
    input  logic                        inflight_wg_buffer_host_wf_done,
    input  logic [WG_ID_WIDTH-1:0]      inflight_wg_buffer_host_wf_done_wg_id,
    output logic                        host_wg_done,
    output logic [WG_ID_WIDTH-1:0]      host_wg_done_id,
    output logic [QUEUE_DEPTH_LOG2:0]   host_queue_count,
    output logic [WG_ID_WIDTH:0]        host_outstanding,
    output logic                        host_all_idle,
    output logic                        host_err
);

    localparam int unsigned NumIds = 1 << WG_ID_WIDTH;

    logic [DESC_W-1:0] head_raw;
    desc_t             head;
    logic              fifo_full, fifo_empty, pop_fire;

    dispatcher_host_desc_fifo #(
        .WIDTH      (DESC_W),
        .DEPTH_LOG2 (QUEUE_DEPTH_LOG2)
    ) u_desc_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (load_valid),
        .wdata_i (load_desc),
        .pop_i   (inflight_wg_buffer_host_rcvd_ack),
        .flush_i (host_flush),
        .rdata_o (head_raw),
        .count_o (host_queue_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head                  = unpack_desc(head_raw);
    assign load_ready            = !fifo_full;
    assign host_wg_valid         = !fifo_empty;
    assign host_wg_id            = head.wg_id;
    assign host_num_wf           = head.num_wf;
    assign host_wf_size          = head.wf_size;
    assign host_vgpr_size_total  = head.vgpr_total;
    assign host_sgpr_size_total  = head.sgpr_total;
    assign host_lds_size_total   = head.lds_total;
    assign host_gds_size_total   = head.gds_total;
    assign host_vgpr_size_per_wf = head.vgpr_per_wf;
    assign host_sgpr_size_per_wf = head.sgpr_per_wf;
    assign host_start_pc         = head.start_pc;

    // A flush in the same cycle swallows the ack, so nothing enters the table.
    assign pop_fire = inflight_wg_buffer_host_rcvd_ack && !fifo_empty && !host_flush;

    logic [NumIds-1:0]         busy_q, busy_d;
    logic [WF_COUNT_WIDTH-1:0] remaining_q [NumIds];
    logic [WF_COUNT_WIDTH-1:0] remaining_d [NumIds];
    logic [WG_ID_WIDTH:0]      outstanding_q, outstanding_d;
    logic                      done_q, done_d;
    logic [WG_ID_WIDTH-1:0]    done_id_q, done_id_d;
    logic                      err_q, err_d;
    logic                      out_inc, out_dec;
    logic [WG_ID_WIDTH-1:0]    wf_id;

    assign wf_id = inflight_wg_buffer_host_wf_done_wg_id;

    always_comb begin
        busy_d      = busy_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        out_inc     = 1'b0;
        out_dec     = 1'b0;

        if (inflight_wg_buffer_host_rcvd_ack && fifo_empty) begin
            err_d = 1'b1;
        end

        if (inflight_wg_buffer_host_wf_done) begin
            if (!busy_q[wf_id]) begin
                err_d = 1'b1;
            end else if (pop_fire && head.wg_id == wf_id) begin
                // Re-dispatch of an id still in flight: the new dispatch wins.
                err_d = 1'b1;
            end else begin
                remaining_d[wf_id] = remaining_q[wf_id] - 1'b1;
                if (remaining_q[wf_id] == WF_COUNT_WIDTH'(1)) begin
                    busy_d[wf_id] = 1'b0;
                    out_dec       = 1'b1;
                    done_d        = 1'b1;
                    done_id_d     = wf_id;
                end
            end
        end

        if (pop_fire) begin
            if (head.num_wf == '0) begin
                err_d = 1'b1;
            end else begin
                if (busy_q[head.wg_id]) begin
                    err_d = 1'b1;
                end else begin
                    out_inc = 1'b1;
                end
                busy_d[head.wg_id]      = 1'b1;
                remaining_d[head.wg_id] = head.num_wf;
            end
        end

        outstanding_d = outstanding_q;
        if (out_inc && !out_dec) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (out_dec && !out_inc) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            for (int unsigned i = 0; i < NumIds; i++) begin
                remaining_q[i] <= '0;
            end
            outstanding_q <= '0;
            done_q        <= 1'b0;
            done_id_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
            done_id_q     <= done_id_d;
            err_q         <= err_d;
        end
    end

    assign host_wg_done     = done_q;
    assign host_wg_done_id  = done_id_q;
    assign host_outstanding = outstanding_q;
    assign host_all_idle    = fifo_empty && (outstanding_q == '0);
    assign host_err         = err_q;

endmodule

// File: doc/dispatcher_host_wg_queue.md
Name: dispatcher_host_wg_queue

Overview:
- Synthesizable, parametrised host-side workgroup source for the dispatcher.
- Buffers workgroup descriptors pushed by a loader/command processor in a FIFO and presents them to inflight_wg_buffer with a valid/ack handshake.
- Tracks per-WG wavefront completion, pulsing a WG-done event and keeping an outstanding count.
- Replaces the simulation-only, single-descriptor host model.

Parameters:
- WG_ID_WIDTH, 6, workgroup id width; completion table has 2^WG_ID_WIDTH entries
- WF_COUNT_WIDTH, 4, wavefront count width
- WAVE_ITEM_WIDTH, 6, work-items in last WF
- VGPR_ID_WIDTH, 8, VGPR size fields are VGPR_ID_WIDTH+1 bits
- SGPR_ID_WIDTH, 4, SGPR size fields are SGPR_ID_WIDTH+1 bits
- LDS_ID_WIDTH, 8, LDS size is LDS_ID_WIDTH+1 bits
- GDS_ID_WIDTH, 14, GDS size is GDS_ID_WIDTH+1 bits
- MEM_ADDR_WIDTH, 32, start PC width
- QUEUE_DEPTH_LOG2, 3, FIFO depth = 2^QUEUE_DEPTH_LOG2 (min 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load_valid  in  1  descriptor push request
- load_ready  out  1  queue can accept (= !full)
- load_desc  in  DESC_W  packed descriptor (package layout)
- host_flush  in  1  drop all queued, not-yet-accepted descriptors
- host_wg_valid  out  1  head descriptor valid
- host_wg_id, host_num_wf, host_wf_size, host_vgpr_size_total, host_sgpr_size_total, host_lds_size_total, host_gds_size_total, host_vgpr_size_per_wf, host_sgpr_size_per_wf, host_start_pc  out  field widths as above  head descriptor fields
- inflight_wg_buffer_host_rcvd_ack  in  1  dispatcher accepted head
- inflight_wg_buffer_host_wf_done  in  1  one WF finished
- inflight_wg_buffer_host_wf_done_wg_id  in  WG_ID_WIDTH  id of finished WF
- host_wg_done  out  1  one-cycle pulse, WG fully complete
- host_wg_done_id  out  WG_ID_WIDTH  id for host_wg_done
- host_queue_count  out  QUEUE_DEPTH_LOG2+1  queued descriptors
- host_outstanding  out  WG_ID_WIDTH+1  accepted, incomplete WGs
- host_all_idle  out  1  queue empty and host_outstanding==0
- host_err  out  1  sticky protocol error

Behaviour:
- Reset (async): FIFO empty; valid=0; all head fields 0; done=0; done_id=0; counts=0; host_all_idle=1; host_err=0; busy bits and remaining counts cleared.
- Push: load_valid&&load_ready writes at tail. load_ready depends only on full, never on same-cycle pop. Descriptor pushed into an empty queue gives host_wg_valid=1 on the next cycle.
- Present: host_wg_valid = !empty. Fields are driven from the head storage flops and stay stable while valid and not acked.
- Pop: ack&&valid pops the head. The next entry is visible the following cycle, with no bubble when count>1. Ack while !valid is ignored and sets host_err.
- Push and pop in the same cycle (not full, not empty): count unchanged. Pointers wrap modulo depth.
- host_flush: empties the FIFO next cycle and has priority over push/pop in that cycle. It does not touch the completion table or the outstanding count.
- Completion table, on accepted pop: remaining[id] <= num_wf, busy[id] <= 1, outstanding+1.
  - If busy[id] is already set: overwrite and set host_err.
  - If num_wf==0: set host_err, do not mark busy.
- wf_done for a busy id: remaining decrements.
  - If the old value was 1: busy<=0, outstanding-1, and host_wg_done=1 with done_id=id on the next cycle (1-cycle latency, registered).
- wf_done for a non-busy id: ignored, sets host_err.
- Pop and wf_done in the same cycle with different ids: both apply; outstanding nets +1/−1 correctly. The same-id case is illegal, and sets host_err with pop taking precedence.
- host_err clears only on rst.

Decomposition:
- Package dispatcher_host_pkg holds DESC_W and each field's LSB/MSB offsets as localparams derived from the width parameters, plus descriptor pack/unpack functions.
- Sub-module dispatcher_host_desc_fifo: generic flop-based sync FIFO (width, depth_log2, push/pop/flush, count/full/empty).
- Completion table and counters stay in the top level.

Test Plan:
- Reset mid-operation with 3 queued, 2 outstanding: assert rst → all outputs at reset values immediately, host_all_idle=1.
- Push 8 descriptors (ids 1..8) into depth 8 with ack held 0 → load_ready=0 after the 8th, count=8. Then ack every cycle → ids 1..8 presented one per cycle in order, with no bubble.
- Push id 5, num_wf=3; ack; send wf_done id 5 three times → host_wg_done pulses once, one cycle after the third done, with done_id=5; outstanding goes 1→0.
- Same cycle: pop id 2 (num_wf=2) and the final wf_done of id 7 → outstanding unchanged, done pulse for 7 next cycle.
- wf_done id 9 never dispatched, and ack with queue empty → state unchanged, host_err=1 and stays set.
- host_flush with 4 queued and 1 outstanding, plus simultaneous push → count=0 next cycle, outstanding stays 1, pushed descriptor dropped.
